peg_scorer: RTL and testbench
=============================

PEG_SCORER -- requirements
Module: peg_scorer

Interface
REQ-001 Parameter: COLOR_W, 3, bit width of one peg colour code.
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  one-cycle request to score the presented code against the presented guess.
REQ-005 Port: clear  input  1  one-cycle request to clear game_over.
REQ-006 Port: code0..code3  input  COLOR_W each  secret code pegs.
REQ-007 Port: guess0..guess3  input  COLOR_W each  submitted guess pegs.
REQ-008 Port: busy  output  1  high while scoring is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when results become valid.
REQ-010 Port: black, white  output  3 each  exact-position matches and colour-only matches, 0..4.
REQ-011 Port: fb0..fb3  output  2 each  per-digit feedback code for the seven-segment converters: 2=black, 1=white, 0=none.
REQ-012 Port: game_over  output  1  sticky flag, set when a scored guess has black==4.

Function
REQ-013 FSM states: IDLE, BLACK, WHITE, PACK, DONE.
REQ-014 In IDLE, start SHALL snapshot code0..3 and guess0..3 into internal registers, set busy, and enter BLACK; later input changes do not affect the result.
REQ-015 BLACK: 4 cycles, index i=0..3; if code_i==guess_i, increment black and mark code peg i and guess peg i as used.
REQ-016 WHITE: 4 cycles, index j=0..3; if guess peg j is unused, the lowest-index unused code peg with equal colour is marked used and white increments; at most one match per guess peg.
REQ-017 PACK: 1 cycle, fill fb3 downward: black entries of 2, then white entries of 1, remaining entries 0 (e.g. black=2, white=1 -> fb3=2, fb2=2, fb1=1, fb0=0).
REQ-018 DONE: 1 cycle, done=1, busy=0, then return to IDLE.
REQ-019 Latency: start sampled at edge N gives done high for exactly the cycle following edge N+10.
REQ-020 black, white, fb0..3 update only on the PACK->DONE transition and hold until the next done.
REQ-021 start while busy SHALL be ignored, with no queuing.
REQ-022 game_over SHALL set on the edge that enters DONE when black==4, and hold until clear or reset.
REQ-023 clear SHALL reset game_over in any state; if clear coincides with a set event, set wins.
REQ-024 Invariant: black+white <= 4; duplicate colours are never double-counted.

Reset
REQ-025 Asserting rst (low) SHALL force IDLE with busy=0, done=0, black=0, white=0, fb0..3=0, game_over=0, and all used-marks cleared, including mid-operation.
REQ-026 After deassertion, the first start is accepted on the next rising edge.

Configuration
REQ-027 Macro PEG_SCORER_WHITE_EN: when defined, WHITE scoring is per REQ-016.
REQ-028 When PEG_SCORER_WHITE_EN is undefined (easy mode), the WHITE state is still traversed for fixed latency, white is forced to 0, and fb never shows 1.

Structure
REQ-029 Shared package mastermind_pkg SHALL hold COLOR_W, NUM_PEGS=4, the feedback codes FB_NONE=0, FB_WHITE=1, FB_BLACK=2, and the FSM state typedef.
REQ-030 Sub-module fb_packer: combinational black/white -> fb0..3 per REQ-017, registered by the parent in PACK.

Verification
REQ-031 code=1,2,3,4, guess=1,2,3,4, start -> done at N+10, black=4, white=0, fb=2,2,2,2, game_over=1.
REQ-032 code=1,1,2,2, guess=2,2,1,1 -> black=0, white=4, fb=1,1,1,1; without PEG_SCORER_WHITE_EN -> white=0, fb=0,0,0,0, same latency.
REQ-033 code=1,1,1,1, guess=1,2,3,4 -> black=1, white=0; code=0,1,2,3, guess=3,3,0,0 -> black=0, white=2, fb3=1, fb2=1.
REQ-034 start pulsed again at N+3 and guess inputs changed at N+1 -> a single done at N+10 with results from the snapshot at N.
REQ-035 rst low at N+5 -> all outputs 0 immediately with no done; start after release scores normally.
REQ-036 game_over=1, then clear -> 0 next edge; clear in the same cycle as a black==4 DONE -> game_over stays 1.

Source files
------------

// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared peg width, feedback codes and scorer FSM states.
package mastermind_pkg;
    localparam int COLOR_W = 3;
    localparam int NUM_PEGS = 4;
    localparam logic [1:0] FB_NONE = 2'd0;
    localparam logic [1:0] FB_WHITE = 2'd1;
    localparam logic [1:0] FB_BLACK = 2'd2;
    typedef enum logic [2:0] {IDLE, BLACK, WHITE, PACK, DONE} state_t;
endpackage

// File: rtl/fb_packer.sv
// fb_packer: maps black/white counts onto fb3..fb0, blacks first from fb3 downward.
module fb_packer
    import mastermind_pkg::*;
(
    input  logic [2:0] i_black,
    input  logic [2:0] i_white,
    output logic [1:0] o_fb0,
    output logic [1:0] o_fb1,
    output logic [1:0] o_fb2,
    output logic [1:0] o_fb3
);
    logic [2:0] w_sum;
    assign w_sum = i_black + i_white;
    assign o_fb3 = (i_black > 3'd0) ? FB_BLACK : (w_sum > 3'd0) ? FB_WHITE : FB_NONE;
    assign o_fb2 = (i_black > 3'd1) ? FB_BLACK : (w_sum > 3'd1) ? FB_WHITE : FB_NONE;
    assign o_fb1 = (i_black > 3'd2) ? FB_BLACK : (w_sum > 3'd2) ? FB_WHITE : FB_NONE;
    assign o_fb0 = (i_black > 3'd3) ? FB_BLACK : (w_sum > 3'd3) ? FB_WHITE : FB_NONE;
endmodule

// File: rtl/peg_scorer.sv
// peg_scorer: sequential Mastermind scorer, 10-cycle start-to-done latency.
// Define PEG_SCORER_WHITE_EN to enable colour-only (white) scoring.
module peg_scorer
    import mastermind_pkg::*;
#(
    parameter int COLOR_W = mastermind_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clear,
    input  logic [COLOR_W-1:0] code0,
    input  logic [COLOR_W-1:0] code1,
    input  logic [COLOR_W-1:0] code2,
    input  logic [COLOR_W-1:0] code3,
    input  logic [COLOR_W-1:0] guess0,
    input  logic [COLOR_W-1:0] guess1,
    input  logic [COLOR_W-1:0] guess2,
    input  logic [COLOR_W-1:0] guess3,
    output logic               busy,
    output logic               done,
    output logic [2:0]         black,
    output logic [2:0]         white,
    output logic [1:0]         fb0,
    output logic [1:0]         fb1,
    output logic [1:0]         fb2,
    output logic [1:0]         fb3,
    output logic               game_over
);
`ifdef PEG_SCORER_WHITE_EN
    localparam bit WHITE_EN = 1'b1;
`else
    localparam bit WHITE_EN = 1'b0;
`endif
    state_t             r_state;
    logic [COLOR_W-1:0] r_code [NUM_PEGS];
    logic [COLOR_W-1:0] r_guess [NUM_PEGS];
    logic [NUM_PEGS-1:0] r_cu;
    logic [NUM_PEGS-1:0] r_gu;
    logic [1:0]         r_idx;
    logic [2:0]         r_bcnt;
    logic [2:0]         r_wcnt;
    logic               w_wfound;
    logic [1:0]         w_wk;
    logic [1:0]         w_fb0, w_fb1, w_fb2, w_fb3;

    // Descending scan so the lowest-index unused matching code peg wins.
    always_comb begin
        w_wfound = 1'b0;
        w_wk = 2'd0;
        for (int k = NUM_PEGS - 1; k >= 0; k--)
            if (!r_cu[k] && r_code[k] == r_guess[r_idx]) begin
                w_wfound = 1'b1;
                w_wk = 2'(k);
            end
    end

    fb_packer u_pack (
        .i_black(r_bcnt),
        .i_white(r_wcnt),
        .o_fb0  (w_fb0),
        .o_fb1  (w_fb1),
        .o_fb2  (w_fb2),
        .o_fb3  (w_fb3)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            for (int k = 0; k < NUM_PEGS; k++) begin
                r_code[k] <= '0;
                r_guess[k] <= '0;
            end
            r_cu <= '0;
            r_gu <= '0;
            r_idx <= 2'd0;
            r_bcnt <= 3'd0;
            r_wcnt <= 3'd0;
            busy <= 1'b0;
            done <= 1'b0;
            black <= 3'd0;
            white <= 3'd0;
            {fb3, fb2, fb1, fb0} <= '0;
            game_over <= 1'b0;
        end else begin
            done <= (r_state == DONE);
            if (clear)
                game_over <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_code <= '{code0, code1, code2, code3};
                    r_guess <= '{guess0, guess1, guess2, guess3};
                    r_cu <= '0;
                    r_gu <= '0;
                    r_idx <= 2'd0;
                    r_bcnt <= 3'd0;
                    r_wcnt <= 3'd0;
                    busy <= 1'b1;
                    r_state <= BLACK;
                end
                BLACK: begin
                    if (r_code[r_idx] == r_guess[r_idx]) begin
                        r_bcnt <= r_bcnt + 3'd1;
                        r_cu[r_idx] <= 1'b1;
                        r_gu[r_idx] <= 1'b1;
                    end
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3)
                        r_state <= WHITE;
                end
                WHITE: begin
                    if (WHITE_EN && !r_gu[r_idx] && w_wfound) begin
                        r_cu[w_wk] <= 1'b1;
                        r_wcnt <= r_wcnt + 3'd1;
                    end
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3)
                        r_state <= PACK;
                end
                PACK: begin
                    black <= r_bcnt;
                    white <= r_wcnt;
                    {fb3, fb2, fb1, fb0} <= {w_fb3, w_fb2, w_fb1, w_fb0};
                    busy <= 1'b0;
                    if (r_bcnt == 3'd4)
                        game_over <= 1'b1;
                    r_state <= DONE;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_peg_scorer.sv
// tb_peg_scorer: directed and random scoring checked against a colour-histogram model.
module tb_peg_scorer;
`ifdef PEG_SCORER_WHITE_EN
    localparam bit WHITE_EN = 1'b1;
`else
    localparam bit WHITE_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, start, clear;
    logic [2:0] code [4];
    logic [2:0] guess [4];
    logic busy, done, game_over;
    logic [2:0] black, white;
    logic [1:0] fb0, fb1, fb2, fb3;
    logic [2:0] sc [4];
    logic [2:0] sg [4];
    int n_cmp = 0;
    int n_err = 0;
    int exp_b, exp_w;
    logic [7:0] exp_fb;
    logic go_exp = 1'b0;

    always #5 clk = ~clk;

    peg_scorer dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .code0(code[0]), .code1(code[1]), .code2(code[2]), .code3(code[3]),
        .guess0(guess[0]), .guess1(guess[1]), .guess2(guess[2]), .guess3(guess[3]),
        .busy(busy), .done(done), .black(black), .white(white),
        .fb0(fb0), .fb1(fb1), .fb2(fb2), .fb3(fb3), .game_over(game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_black"}, black, 0);
        chk({tag, "_white"}, white, 0);
        chk({tag, "_fb"}, {fb3, fb2, fb1, fb0}, 0);
        chk({tag, "_game_over"}, game_over, 0);
    endtask

    // Exact hits by position; total hits as sum of per-colour minimum counts.
    task automatic model();
        int common, cc, cg, r;
        exp_b = 0;
        common = 0;
        for (int i = 0; i < 4; i++) if (sc[i] == sg[i]) exp_b++;
        for (int col = 0; col < 8; col++) begin
            cc = 0; cg = 0;
            for (int i = 0; i < 4; i++) begin
                if (sc[i] == 3'(col)) cc++;
                if (sg[i] == 3'(col)) cg++;
            end
            common += (cc < cg) ? cc : cg;
        end
        exp_w = WHITE_EN ? common - exp_b : 0;
        exp_fb = '0;
        for (r = 0; r < 4; r++)
            exp_fb[2*(3-r) +: 2] = (r < exp_b) ? 2'd2 : (r < exp_b + exp_w) ? 2'd1 : 2'd0;
        if (exp_b == 4) go_exp = 1'b1;
    endtask

    task automatic set_pegs(input logic [11:0] c, input logic [11:0] g);
        for (int i = 0; i < 4; i++) begin
            code[i] = c[3*(3-i) +: 3];
            guess[i] = g[3*(3-i) +: 3];
        end
    endtask

    task automatic score(input string tag, input bit perturb, input bit clr_pack);
        int dn, dc;
        sc = code;
        sg = guess;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (perturb) for (int i = 0; i < 4; i++) guess[i] = guess[i] + 3'd1;
        dn = 0; dc = 0;
        for (int k = 1; k <= 13; k++) begin
            if (perturb && k == 3) start = 1'b1;
            if (perturb && k == 4) start = 1'b0;
            if (clr_pack && k == 9) clear = 1'b1;
            if (clr_pack && k == 10) clear = 1'b0;
            @(posedge clk); #1;
            if (done) begin dn++; dc = k; end
            if (k == 1) chk({tag, "_busy_run"}, busy, 1);
            if (k == 9) chk({tag, "_busy_done"}, busy, 0);
        end
        model();
        chk({tag, "_done_count"}, dn, 1);
        chk({tag, "_latency"}, dc, 10);
        chk({tag, "_black"}, black, exp_b);
        chk({tag, "_white"}, white, exp_w);
        chk({tag, "_fb"}, {fb3, fb2, fb1, fb0}, exp_fb);
        chk({tag, "_game_over"}, game_over, go_exp);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        go_exp = 1'b0;
        chk("clear_game_over", game_over, go_exp);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; clear = 1'b0;
        set_pegs(12'o0000, 12'o0000);
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        set_pegs(12'o1234, 12'o1234);
        score("exact4", 1'b0, 1'b0);
        chk("exact4_fb_literal", {fb3, fb2, fb1, fb0}, 8'b10101010);
        chk("exact4_go_literal", game_over, 1);
        do_clear();

        set_pegs(12'o1122, 12'o2211);
        score("swap", 1'b0, 1'b0);
        chk("swap_white_literal", white, WHITE_EN ? 4 : 0);
        set_pegs(12'o1111, 12'o1234);
        score("dup_code", 1'b0, 1'b0);
        chk("dup_code_black_literal", black, 1);
        set_pegs(12'o0123, 12'o3300);
        score("dup_guess", 1'b0, 1'b0);
        chk("dup_guess_fb32_literal", {fb3, fb2}, WHITE_EN ? 4'b0101 : 4'b0000);

        set_pegs(12'o5670, 12'o5432);
        score("snapshot", 1'b1, 1'b0);

        do_clear();
        set_pegs(12'o7777, 12'o7777);
        score("set_wins", 1'b0, 1'b1);

        set_pegs(12'o1234, 12'o4321);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_zero("midrst");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 chk("midrst_no_done", done, 0);
        end
        go_exp = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        score("after_rst", 1'b0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 4; i++) begin
                code[i] = 3'($urandom_range(0, 3));
                guess[i] = 3'($urandom_range(0, 3));
            end
            score("rand", 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
